// File: rtl/aes_cmd_pkg.sv
// Shared definitions for the AES command sequencer: frame layout, opcodes,
// FSM state encoding and status bit positions.
package aes_cmd_pkg;

    localparam int unsigned FRAME_W  = 144;
    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned STATUS_W = 8;

    localparam logic [BYTE_W-1:0] OP_KEY  = 8'h42;
    localparam logic [BYTE_W-1:0] OP_ENC  = 8'h43;
    localparam logic [BYTE_W-1:0] OP_READ = 8'h44;
    localparam logic [BYTE_W-1:0] OP_DEC  = 8'h45;
    localparam logic [BYTE_W-1:0] OP_CLR  = 8'h60;

    // Status bit indices
    localparam int unsigned SB_BUSY       = 0;
    localparam int unsigned SB_RES_VALID  = 1;
    localparam int unsigned SB_TIMEOUT    = 2;
    localparam int unsigned SB_BAD_FRAME  = 3;
    localparam int unsigned SB_DROPPED    = 4;
    localparam int unsigned SB_KEY_LOADED = 5;
    localparam int unsigned SB_LAST_DEC   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_REPLY = 2'd3
    } state_e;

    // UART frame: byte17 = end char, bytes16..1 = payload, byte0 = opcode
    typedef struct packed {
        logic [BYTE_W-1:0]  end_char;
        logic [BLOCK_W-1:0] payload;
        logic [BYTE_W-1:0]  opcode;
    } frame_t;

endpackage

// File: rtl/aes_cmd_decode.sv
// Combinational frame check and opcode one-hot decode.
// Ports: frame_data (raw 18-byte frame) -> payload, is_key/is_enc/is_dec/
// is_read/is_clr/is_bad. Opcode 0x45 decodes only when AES_DECRYPT_EN is defined.
module aes_cmd_decode
    import aes_cmd_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_data,
    output logic [BLOCK_W-1:0] payload,
    output logic               is_key,
    output logic               is_enc,
    output logic               is_dec,
    output logic               is_read,
    output logic               is_clr,
    output logic               is_bad
);

    frame_t frame;
    assign frame   = frame_t'(frame_data);
    assign payload = frame.payload;

    // Malformed (end char != opcode) or unknown opcode flags is_bad
    always_comb begin
        is_key  = 1'b0;
        is_enc  = 1'b0;
        is_dec  = 1'b0;
        is_read = 1'b0;
        is_clr  = 1'b0;
        is_bad  = 1'b0;
        if (frame.end_char != frame.opcode) begin
            is_bad = 1'b1;
        end else begin
            case (frame.opcode)
                OP_KEY:  is_key  = 1'b1;
                OP_ENC:  is_enc  = 1'b1;
                OP_READ: is_read = 1'b1;
                OP_CLR:  is_clr  = 1'b1;
`ifdef AES_DECRYPT_EN
                OP_DEC:  is_dec  = 1'b1;
`endif
                default: is_bad  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Sequences the AES engine from decoded UART command frames and schedules
// reply frames on the UART TX path.
// Ports: clk/nreset; frame_valid/frame_data/frame_ready (command in);
// aes_key/aes_data/aes_start/aes_dec_sel/aes_res/aes_res_v (engine);
// tx_frame/tx_start/tx_busy (UART TX); status, drop_cnt.
// Build option: AES_DECRYPT_EN enables the decrypt opcode 0x45.
module aes_cmd_sequencer
    import aes_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                frame_valid,
    input  logic [FRAME_W-1:0]  frame_data,
    output logic                frame_ready,
    output logic [BLOCK_W-1:0]  aes_key,
    output logic [BLOCK_W-1:0]  aes_data,
    output logic                aes_start,
    output logic                aes_dec_sel,
    input  logic [BLOCK_W-1:0]  aes_res,
    input  logic                aes_res_v,
    output logic [FRAME_W-1:0]  tx_frame,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [STATUS_W-1:0] status,
    output logic [CNT_W-1:0]    drop_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [BLOCK_W-1:0] payload, result_q;
    logic is_key, is_enc, is_dec, is_read, is_clr, is_bad;
    logic load_key, load_enc, load_dec, capture, set_timeout;
    logic do_reply, do_clr, set_bad, do_drop;
    logic busy_q, res_valid_q, timeout_q, bad_q, dropped_q, key_loaded_q;
    logic dec_sel_q, last_dec_q;

    aes_cmd_decode u_decode (
        .frame_data (frame_data),
        .payload    (payload),
        .is_key     (is_key),
        .is_enc     (is_enc),
        .is_dec     (is_dec),
        .is_read    (is_read),
        .is_clr     (is_clr),
        .is_bad     (is_bad)
    );

    // State and timer registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        load_key    = 1'b0;
        load_enc    = 1'b0;
        load_dec    = 1'b0;
        capture     = 1'b0;
        set_timeout = 1'b0;
        do_reply    = 1'b0;
        do_clr      = 1'b0;
        set_bad     = 1'b0;
        do_drop     = frame_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    if (is_bad) begin
                        set_bad = 1'b1;
                    end else if (is_key) begin
                        load_key = 1'b1;
                    end else if (is_enc) begin
                        load_enc = 1'b1;
                        state_d  = ST_ISSUE;
                    end else if (is_dec) begin
                        load_dec = 1'b1;
                        state_d  = ST_ISSUE;
                    end else if (is_read) begin
                        state_d = ST_REPLY;
                    end else if (is_clr) begin
                        do_clr = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the final timer cycle takes priority over the timeout
                if (aes_res_v) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_REPLY: begin
                if (!tx_busy) begin
                    do_reply = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            frame_ready  <= 1'b1;
            busy_q       <= 1'b0;
            aes_key      <= '0;
            aes_data     <= '0;
            aes_start    <= 1'b0;
            result_q     <= '0;
            res_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            bad_q        <= 1'b0;
            dropped_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            drop_cnt     <= '0;
            tx_frame     <= '0;
            tx_start     <= 1'b0;
        end else begin
            frame_ready <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            // Start pulse lands in the first WAIT cycle: two cycles after the frame
            aes_start   <= (state_q == ST_ISSUE);
            tx_start    <= do_reply;
            if (load_key) begin
                aes_key      <= payload;
                key_loaded_q <= 1'b1;
            end
            if (load_enc || load_dec) begin
                aes_data <= payload;
            end
            if (capture) begin
                result_q    <= aes_res;
                res_valid_q <= 1'b1;
                timeout_q   <= 1'b0;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (set_bad) begin
                bad_q <= 1'b1;
            end
            if (do_drop) begin
                dropped_q <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
            if (do_clr) begin
                timeout_q <= 1'b0;
                bad_q     <= 1'b0;
                dropped_q <= 1'b0;
                drop_cnt  <= '0;
            end
            if (do_reply) begin
                tx_frame <= {status, result_q, OP_READ};
            end
        end
    end

`ifdef AES_DECRYPT_EN
    // Engine select follows the most recent encrypt/decrypt command
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dec_sel_q  <= 1'b0;
            last_dec_q <= 1'b0;
        end else if (load_enc) begin
            dec_sel_q  <= 1'b0;
            last_dec_q <= 1'b0;
        end else if (load_dec) begin
            dec_sel_q  <= 1'b1;
            last_dec_q <= 1'b1;
        end
    end
`else
    assign dec_sel_q  = 1'b0;
    assign last_dec_q = 1'b0;
`endif

    assign aes_dec_sel = dec_sel_q;
    assign status = {1'b0, last_dec_q, key_loaded_q, dropped_q,
                     bad_q, timeout_q, res_valid_q, busy_q};

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: main instance (default timeout) with a
// fixed-latency engine model, plus a TIMEOUT_CYCLES = 8 instance.
module tb_aes_cmd_sequencer;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'hdeadbeef_00000000_11111111_22222222;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R2   = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

    logic         clk = 1'b0;
    logic         nreset;
    logic         frame_valid, frame_valid2;
    logic [143:0] frame_data;
    logic         aes_res_v2;
    logic         tx_busy;
    logic         eng_en;
    int           eng_cnt;

    logic         frame_ready, aes_start, aes_dec_sel, aes_res_v, tx_start;
    logic [127:0] aes_key, aes_data;
    logic [143:0] tx_frame;
    logic [7:0]   status, drop_cnt;

    logic         frame_ready2, aes_start2, aes_dec_sel2, tx_start2;
    logic [127:0] aes_key2, aes_data2;
    logic [143:0] tx_frame2;
    logic [7:0]   status2, drop_cnt2;

    int errors = 0;
    int checks = 0;
    int cnt;

    always #5 clk = ~clk;

    aes_cmd_sequencer dut (
        .clk(clk), .nreset(nreset), .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ready(frame_ready), .aes_key(aes_key), .aes_data(aes_data),
        .aes_start(aes_start), .aes_dec_sel(aes_dec_sel), .aes_res(CT),
        .aes_res_v(aes_res_v), .tx_frame(tx_frame), .tx_start(tx_start),
        .tx_busy(tx_busy), .status(status), .drop_cnt(drop_cnt)
    );

    aes_cmd_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut8 (
        .clk(clk), .nreset(nreset), .frame_valid(frame_valid2), .frame_data(frame_data),
        .frame_ready(frame_ready2), .aes_key(aes_key2), .aes_data(aes_data2),
        .aes_start(aes_start2), .aes_dec_sel(aes_dec_sel2), .aes_res(R2),
        .aes_res_v(aes_res_v2), .tx_frame(tx_frame2), .tx_start(tx_start2),
        .tx_busy(tx_busy), .status(status2), .drop_cnt(drop_cnt2)
    );

    // Engine model: result valid for one cycle, 11 cycles after the start pulse
    always @(posedge clk) begin
        if (!nreset)                  eng_cnt <= 0;
        else if (aes_start && eng_en) eng_cnt <= 11;
        else if (eng_cnt > 0)         eng_cnt <= eng_cnt - 1;
    end
    assign aes_res_v = (eng_cnt == 1);

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one frame for one cycle; returns at the following negedge
    task automatic send(input logic [7:0] op, input logic [127:0] pl,
                        input logic [7:0] ec, input bit to_dut8);
        frame_data = {ec, pl, op};
        if (to_dut8) frame_valid2 = 1'b1;
        else         frame_valid  = 1'b1;
        @(negedge clk);
        frame_valid  = 1'b0;
        frame_valid2 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; frame_valid = 1'b0; frame_valid2 = 1'b0; frame_data = '0;
        aes_res_v2 = 1'b0; tx_busy = 1'b0; eng_en = 1'b1;
        tick(); tick();
        check("rst_frame_ready", 144'(frame_ready), 144'(1'b1));
        check("rst_status", 144'(status), 144'(8'h00));
        check("rst_drop_cnt", 144'(drop_cnt), 144'(8'h00));
        check("rst_aes_key", 144'(aes_key), 144'(0));
        check("rst_tx_frame", tx_frame, 144'(0));
        check("rst_aes_start", 144'(aes_start), 144'(0));
        check("rst_frame_ready8", 144'(frame_ready2), 144'(1'b1));
        nreset = 1'b1;
        tick();

        // Timeout instance: one successful op, then a timed-out op
        send(8'h43, PT, 8'h43, 1'b1);
        tick();
        aes_res_v2 = 1'b1;
        tick();
        aes_res_v2 = 1'b0;
        check("t8_capture_status", 144'(status2), 144'(8'h02));
        send(8'h43, PT2, 8'h43, 1'b1);
        tick();                                   // WAIT entered here
        repeat (7) tick();
        check("t8_no_timeout_yet", 144'(status2), 144'(8'h03));
        tick();
        check("t8_timeout_at_8", 144'(status2), 144'(8'h06));
        check("t8_idle_after_to", 144'(frame_ready2), 144'(1'b1));
        send(8'h44, '0, 8'h44, 1'b1);
        tick();
        check("t8_tx_start", 144'(tx_start2), 144'(1'b1));
        check("t8_old_result_kept", tx_frame2, {8'h07, R2, 8'h44});

        // 1: key load, encrypt, read back
        send(8'h42, KEY, 8'h42, 1'b0);
        check("t1_key", 144'(aes_key), 144'(KEY));
        check("t1_key_status", 144'(status), 144'(8'h20));
        send(8'h43, PT, 8'h43, 1'b0);
        check("t1_start_lat1", 144'(aes_start), 144'(0));
        check("t1_busy_ready", 144'(frame_ready), 144'(0));
        check("t1_data", 144'(aes_data), 144'(PT));
        tick();
        check("t1_start_lat2", 144'(aes_start), 144'(1));
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (aes_start) cnt++;
            if (status[1]) break;
        end
        check("t1_one_start", 144'(cnt), 144'(1));
        check("t1_res_status", 144'(status), 144'(8'h22));
        send(8'h44, '0, 8'h44, 1'b0);
        check("t1_tx_not_yet", 144'(tx_start), 144'(0));
        tick();
        check("t1_tx_start", 144'(tx_start), 144'(1));
        check("t1_tx_frame", tx_frame, {8'h23, CT, 8'h44});
        tick();
        check("t1_tx_pulse_end", 144'(tx_start), 144'(0));
        check("t1_idle", 144'(frame_ready), 144'(1));

        // 3: malformed frame, then clear
        send(8'h43, PT2, 8'h41, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (aes_start) cnt++;
            tick();
        end
        check("t3_bad_no_start", 144'(cnt), 144'(0));
        check("t3_bad_status", 144'(status), 144'(8'h2a));
        check("t3_data_unchanged", 144'(aes_data), 144'(PT));
        send(8'h60, '0, 8'h60, 1'b0);
        check("t3_clear", 144'(status), 144'(8'h22));

        // 4: drops during WAIT, then timeout with result kept
        eng_en = 1'b0;
        send(8'h43, PT2, 8'h43, 1'b0);
        tick();
        repeat (3) send(8'h42, KEY2, 8'h42, 1'b0);
        check("t4_drop_cnt", 144'(drop_cnt), 144'(8'd3));
        check("t4_dropped", 144'(status[4]), 144'(1));
        check("t4_key_kept", 144'(aes_key), 144'(KEY));
        for (int i = 0; i < 300; i++) begin
            if (status[2]) break;
            tick();
        end
        check("t4_timeout_status", 144'(status), 144'(8'h36));
        eng_en = 1'b1;

        // 5: reply held off by tx_busy; drop counter saturation meanwhile
        tx_busy = 1'b1;
        send(8'h44, '0, 8'h44, 1'b0);
        cnt = 0;
        for (int i = 0; i < 260; i++) begin
            if (tx_start) cnt++;
            send(8'h42, KEY2, 8'h42, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            if (tx_start) cnt++;
            tick();
        end
        check("t5_no_tx_while_busy", 144'(cnt), 144'(0));
        check("t5_drop_sat", 144'(drop_cnt), 144'(8'hff));
        check("t5_key_kept", 144'(aes_key), 144'(KEY));
        tx_busy = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start) cnt++;
        end
        check("t5_one_tx", 144'(cnt), 144'(1));
        check("t5_tx_frame", tx_frame, {8'h37, CT, 8'h44});

        // 6: reset mid-WAIT aborts; reply then carries no result
        send(8'h43, PT, 8'h43, 1'b0);
        tick();
        check("t6_start_before_rst", 144'(aes_start), 144'(1));
        nreset = 1'b0;
        #1;
        check("t6_start_async_drop", 144'(aes_start), 144'(0));
        check("t6_ready_async", 144'(frame_ready), 144'(1));
        tick();
        nreset = 1'b1;
        tick();
        check("t6_status_after_rst", 144'(status), 144'(8'h00));
        send(8'h44, '0, 8'h44, 1'b0);
        tick();
        check("t6_tx_start", 144'(tx_start), 144'(1));
        check("t6_tx_frame", tx_frame, {8'h01, 128'h0, 8'h44});
        tick();

        // Decrypt opcode
        send(8'h45, CT, 8'h45, 1'b0);
`ifdef AES_DECRYPT_EN
        check("t6_dec_sel", 144'(aes_dec_sel), 144'(1));
        check("t6_last_dec", 144'(status[6]), 144'(1));
`else
        check("t6_dec_bad", 144'(status), 144'(8'h08));
        check("t6_dec_sel_tied", 144'(aes_dec_sel), 144'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
